// File: rtl/wb_data_master.sv
// wb_data_master
// Wishbone B4 pipelined-mode initiator for the core's data-side memory stage.
// Converts one load/store request at a time into one bus transaction and
// returns read data or an error as a single-cycle response pulse.
//
// Optional feature: define WB_MASTER_TIMEOUT_EN to build a watchdog that
// terminates a transaction with an error once it has been open for
// TIMEOUT_CYCLES cycles without ack/err. Without the macro the transaction
// stays open until the slave answers and TIMEOUT_CYCLES is ignored.

module wb_data_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    // Core request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,

    // Core response side
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    // Wishbone initiator
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic        timeout_hit;
    logic        bus_done;

    logic        we_reg;
    logic [31:0] adr_reg;
    logic [31:0] dat_reg;
    logic [3:0]  sel_reg;

    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [31:0] resp_rdata_reg;

    // A named marker scope appears in the elaborated hierarchy when the
    // parameter is outside its supported range, making misconfiguration easy
    // to spot in synthesis reports.
    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
        end
    endgenerate

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_reg;

    // Watchdog: cleared while idle (so it starts at 0 on the handshake edge),
    // counts every cycle the bus cycle is open.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    // The counter reaches TIMEOUT_CYCLES on this edge, so completion is
    // registered on the same edge: cyc stays open exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = (state_reg != ST_IDLE) && (tmo_cnt_reg == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Responses are only honoured while the bus cycle is open; anything
    // arriving with cyc low is a spurious or late answer and is dropped.
    assign bus_done = (state_reg != ST_IDLE) && (wb_ack_i || wb_err_i || timeout_hit);

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a response in REQ completes directly, even in the
    // acceptance cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_done) begin
                    state_next = ST_IDLE;
                end else if (!wb_stall_i) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bus control outputs decode straight from the state so that an
    // asynchronous reset drops cyc/stb immediately.
    always_comb begin
        req_ready = 1'b0;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        case (state_reg)
            ST_IDLE: req_ready = 1'b1;
            ST_REQ: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
            end
            ST_WAIT: wb_cyc_o = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Capture the request at the handshake and hold it until the next one;
    // write data is zeroed for loads.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_reg  <= 1'b0;
            adr_reg <= '0;
            dat_reg <= '0;
            sel_reg <= '0;
        end else if (state_reg == ST_IDLE && req_valid) begin
            we_reg  <= req_we;
            adr_reg <= req_addr;
            dat_reg <= req_we ? req_wdata : 32'h0;
            sel_reg <= req_be;
        end
    end

    // One-cycle response pulse; err beats ack, an ack beats a coincident
    // timeout, and read data is only returned for a clean load ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            resp_valid_reg <= bus_done;
            resp_err_reg   <= bus_done && (wb_err_i || (timeout_hit && !wb_ack_i));
            resp_rdata_reg <= (bus_done && wb_ack_i && !wb_err_i && !we_reg) ? wb_dat_i : 32'h0;
        end
    end

    assign wb_we_o    = we_reg;
    assign wb_adr_o   = adr_reg;
    assign wb_dat_o   = dat_reg;
    assign wb_sel_o   = sel_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_wb_data_master.sv
// Directed testbench for wb_data_master. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.

module tb_wb_data_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] wb_dat_i;

    int checks = 0;
    int errors = 0;

    wb_data_master #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stall_i (wb_stall_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_dat_i   (wb_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_be     = 4'h0;
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_dat_i   = 32'h0;

        // ---------------- reset state ----------------
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_adr", wb_adr_o, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        $display("reset released");

        // ---------------- load, ack cycle after acceptance ----------------
        issue(1'b0, 32'h0001_0004, 32'hAAAA_5555, 4'hC);
        tick();                                   // E0 handshake
        req_valid = 1'b0;
        check("ld1_cyc", {31'd0, wb_cyc_o}, 32'd1);
        check("ld1_stb", {31'd0, wb_stb_o}, 32'd1);
        check("ld1_we", {31'd0, wb_we_o}, 32'd0);
        check("ld1_adr", wb_adr_o, 32'h0001_0004);
        check("ld1_sel", {28'd0, wb_sel_o}, 32'hC);
        check("ld1_dat_o_zero", wb_dat_o, 32'h0);
        check("ld1_ready_busy", {31'd0, req_ready}, 32'd0);
        tick();                                   // E1 accepted
        check("ld1_stb_drop", {31'd0, wb_stb_o}, 32'd0);
        check("ld1_cyc_wait", {31'd0, wb_cyc_o}, 32'd1);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        tick();                                   // E2 ack sampled
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        check("ld1_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("ld1_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("ld1_err", {31'd0, resp_err}, 32'd0);
        check("ld1_cyc_done", {31'd0, wb_cyc_o}, 32'd0);
        check("ld1_ready_resp", {31'd0, req_ready}, 32'd1);
        tick();
        check("ld1_resp_pulse", {31'd0, resp_valid}, 32'd0);
        $display("txn load 0x00010004 rdata=%h err=%0d", 32'hDEAD_BEEF, 0);

        // ---------------- store with 3 stall cycles ----------------
        wb_stall_i = 1'b1;
        issue(1'b1, 32'h0000_8008, 32'h1234_5678, 4'hF);
        tick();                                   // E0
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("st_stb_stall", {31'd0, wb_stb_o}, 32'd1);
            check("st_adr_stable", wb_adr_o, 32'h0000_8008);
            check("st_dat_stable", wb_dat_o, 32'h1234_5678);
            tick();                               // E1..E3
        end
        check("st_stb_4th", {31'd0, wb_stb_o}, 32'd1);
        check("st_we", {31'd0, wb_we_o}, 32'd1);
        wb_stall_i = 1'b0;
        tick();                                   // E4 accepted
        check("st_stb_drop", {31'd0, wb_stb_o}, 32'd0);
        check("st_cyc_wait", {31'd0, wb_cyc_o}, 32'd1);
        check("st_dat_wait", wb_dat_o, 32'h1234_5678);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hFFFF_FFFF;
        tick();                                   // E5 ack
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        check("st_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("st_rdata_zero", resp_rdata, 32'h0);
        check("st_err", {31'd0, resp_err}, 32'd0);
        tick();
        $display("txn store 0x00008008 wdata=%h", 32'h1234_5678);

        // ---------------- spurious ack while idle ----------------
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h5555_AAAA;
        tick();
        wb_ack_i = 1'b0;
        check("spur_no_resp", {31'd0, resp_valid}, 32'd0);
        tick();
        check("spur_no_resp2", {31'd0, resp_valid}, 32'd0);
        $display("txn spurious ack dropped");

        // ---------------- ack+err together in acceptance cycle ----------------
        issue(1'b0, 32'h0000_0020, 32'h0, 4'hF);
        tick();                                   // E0
        req_valid = 1'b0;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        wb_dat_i = 32'h1122_3344;
        tick();                                   // E1 accept + response
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        check("ackerr_valid", {31'd0, resp_valid}, 32'd1);
        check("ackerr_err", {31'd0, resp_err}, 32'd1);
        check("ackerr_rdata", resp_rdata, 32'h0);
        check("ackerr_cyc", {31'd0, wb_cyc_o}, 32'd0);
        tick();
        check("ackerr_pulse", {31'd0, resp_valid}, 32'd0);
        $display("txn load 0x00000020 ack+err -> err");

        // ---------------- minimum-latency ack-only load ----------------
        issue(1'b0, 32'h0000_0030, 32'h0, 4'h3);
        tick();                                   // E0
        req_valid = 1'b0;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0BAD_F00D;
        tick();                                   // E1
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        check("minlat_valid", {31'd0, resp_valid}, 32'd1);
        check("minlat_rdata", resp_rdata, 32'h0BAD_F00D);
        check("minlat_err", {31'd0, resp_err}, 32'd0);
        tick();
        $display("txn load 0x00000030 rdata=%h (min latency)", 32'h0BAD_F00D);

`ifdef WB_MASTER_TIMEOUT_EN
        // ---------------- watchdog, silent slave ----------------
        issue(1'b0, 32'h0000_0050, 32'h0, 4'hF);
        tick();                                   // E0
        req_valid = 1'b0;
        check("tmo_cyc_open0", {31'd0, wb_cyc_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();                               // E1..E3
            check("tmo_cyc_open", {31'd0, wb_cyc_o}, 32'd1);
            check("tmo_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        tick();                                   // E4 timeout
        check("tmo_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
        check("tmo_valid", {31'd0, resp_valid}, 32'd1);
        check("tmo_err", {31'd0, resp_err}, 32'd1);
        check("tmo_rdata", resp_rdata, 32'h0);
        tick();
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("tmo_late_ack", {31'd0, resp_valid}, 32'd0);
        $display("txn load 0x00000050 timeout -> err");
`endif

        // ---------------- async reset while in WAIT ----------------
        issue(1'b0, 32'h0000_0060, 32'h0, 4'hF);
        tick();                                   // E0
        req_valid = 1'b0;
        tick();                                   // E1 accepted
        check("rstw_in_wait", {31'd0, wb_cyc_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstw_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rstw_stb", {31'd0, wb_stb_o}, 32'd0);
        check("rstw_resp", {31'd0, resp_valid}, 32'd0);
        check("rstw_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check("rstw_no_resp", {31'd0, resp_valid}, 32'd0);
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h1);
        tick();                                   // E0
        req_valid = 1'b0;
        check("rstw_new_adr", wb_adr_o, 32'h0000_0040);
        tick();                                   // E1
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hCAFE_F00D;
        tick();                                   // E2
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        check("rstw_new_valid", {31'd0, resp_valid}, 32'd1);
        check("rstw_new_rdata", resp_rdata, 32'hCAFE_F00D);
        tick();
        $display("txn reset in WAIT, then load 0x00000040 rdata=%h", 32'hCAFE_F00D);

        // ---------------- back-to-back loads ----------------
        issue(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        tick();                                   // E0 first handshake
        check("b2b_stb1", {31'd0, wb_stb_o}, 32'd1);
        tick();                                   // E1 accepted
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_00A1;
        tick();                                   // E2 ack
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        req_addr = 32'h0000_0104;
        check("b2b_resp1", {31'd0, resp_valid}, 32'd1);
        check("b2b_rdata1", resp_rdata, 32'h0000_00A1);
        check("b2b_gap_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("b2b_gap_ready", {31'd0, req_ready}, 32'd1);
        tick();                                   // E3 second handshake
        req_valid = 1'b0;
        check("b2b_stb2", {31'd0, wb_stb_o}, 32'd1);
        check("b2b_cyc2", {31'd0, wb_cyc_o}, 32'd1);
        check("b2b_adr2", wb_adr_o, 32'h0000_0104);
        check("b2b_resp_gone", {31'd0, resp_valid}, 32'd0);
        tick();                                   // E4 accepted
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_00B2;
        tick();                                   // E5 ack
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        check("b2b_resp2", {31'd0, resp_valid}, 32'd1);
        check("b2b_rdata2", resp_rdata, 32'h0000_00B2);
        tick();
        $display("txn back-to-back loads 0x00000100/0x00000104");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
